// File: rtl/vending_machine_controller.sv
// Vending machine sequencing controller: registered balance, inactivity timer
// and greedy change-return sequencer driving one-cycle dispense/return pulses.
module vending_machine_controller #(
   parameter int kNumCoins   = 3,
   parameter int kNumItems   = 4,
   parameter int kTotalBits  = 31,
   parameter int kWaitTime   = 100,
   parameter int COIN_VAL0   = 100,
   parameter int COIN_VAL1   = 500,
   parameter int COIN_VAL2   = 1000,
   parameter int ITEM_PRICE0 = 400,
   parameter int ITEM_PRICE1 = 500,
   parameter int ITEM_PRICE2 = 1000,
   parameter int ITEM_PRICE3 = 2000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [kNumCoins-1:0]  i_input_coin,
   input  logic [kNumItems-1:0]  i_select_item,
   input  logic                  i_trigger_return,
   output logic [kNumItems-1:0]  o_available_item,
   output logic [kNumItems-1:0]  o_output_item,
   output logic [kNumCoins-1:0]  o_return_coin,
   output logic [kTotalBits-1:0] o_current_total,
   output logic [1:0]            o_state,
   output logic                  o_busy
);
   localparam int kCntBits = $clog2(kWaitTime + 1);

   typedef logic [kTotalBits-1:0] bal_t;
   typedef logic [kTotalBits:0]   wide_t;
   typedef logic [kCntBits-1:0]   cnt_t;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_RETURN = 2'd2
   } state_t;

   localparam cnt_t kWaitLoad = cnt_t'(kWaitTime);

   function automatic bal_t coin_value(input int idx);
      case (idx)
         0:       coin_value = bal_t'(COIN_VAL0);
         1:       coin_value = bal_t'(COIN_VAL1);
         2:       coin_value = bal_t'(COIN_VAL2);
         default: coin_value = '0;
      endcase
   endfunction

   function automatic bal_t item_price(input int idx);
      case (idx)
         0:       item_price = bal_t'(ITEM_PRICE0);
         1:       item_price = bal_t'(ITEM_PRICE1);
         2:       item_price = bal_t'(ITEM_PRICE2);
         3:       item_price = bal_t'(ITEM_PRICE3);
         default: item_price = '0;
      endcase
   endfunction

   state_t                state_q, state_d;
   bal_t                  balance_q, balance_d;
   cnt_t                  wait_q, wait_d;
   logic [kNumItems-1:0]  item_q, item_d;
   logic [kNumCoins-1:0]  coin_q, coin_d;

   logic  coin_hit, sel_hit, coin_ok, can_buy;
   int    coin_idx, sel_idx, ret_idx;
   bal_t  coin_val, price, added, ret_val;
   wide_t sum;

   // Input decode: lowest set bit wins; sum carries one extra bit so an
   // overflowing coin can be detected and rejected.
   always_comb begin
      coin_hit = 1'b0;
      coin_idx = 0;
      for (int i = kNumCoins - 1; i >= 0; i--) begin
         if (i_input_coin[i]) begin
            coin_hit = 1'b1;
            coin_idx = i;
         end
      end
      sel_hit = 1'b0;
      sel_idx = 0;
      for (int i = kNumItems - 1; i >= 0; i--) begin
         if (i_select_item[i]) begin
            sel_hit = 1'b1;
            sel_idx = i;
         end
      end
      ret_idx = -1;
      for (int i = 0; i < kNumCoins; i++) begin
         if (coin_value(i) <= balance_q) ret_idx = i;
      end
      coin_val = coin_hit ? coin_value(coin_idx) : '0;
      price    = sel_hit ? item_price(sel_idx) : '0;
      ret_val  = coin_value(ret_idx);
      sum      = {1'b0, balance_q} + {1'b0, coin_val};
      coin_ok  = coin_hit && !sum[kTotalBits];
      added    = coin_ok ? sum[kTotalBits-1:0] : balance_q;
      can_buy  = sel_hit && (added >= price);
   end

   always_comb begin
      state_d   = state_q;
      balance_d = balance_q;
      wait_d    = wait_q;
      item_d    = '0;
      coin_d    = '0;
      unique case (state_q)
         S_IDLE: begin
            if (coin_ok) begin
               state_d   = S_ACTIVE;
               balance_d = added;
               wait_d    = kWaitLoad;
            end
         end
         S_ACTIVE: begin
            if (i_trigger_return) begin
               state_d   = S_RETURN;
               balance_d = added;
            end else if (can_buy) begin
               balance_d       = added - price;
               item_d[sel_idx] = 1'b1;
               wait_d          = kWaitLoad;
            end else begin
               balance_d = added;
               if (coin_ok) begin
                  wait_d = kWaitLoad;
               end else begin
                  if (wait_q != '0) wait_d = wait_q - cnt_t'(1);
                  if (wait_q == cnt_t'(1)) state_d = S_RETURN;
               end
            end
         end
         // One greedy coin per cycle; a remainder below the smallest coin is dropped.
         S_RETURN: begin
            wait_d = '0;
            if (ret_idx >= 0) begin
               balance_d       = balance_q - ret_val;
               coin_d[ret_idx] = 1'b1;
               if (balance_q == ret_val) state_d = S_IDLE;
            end else begin
               balance_d = '0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d   = S_IDLE;
            balance_d = '0;
            wait_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         balance_q <= '0;
         wait_q    <= '0;
         item_q    <= '0;
         coin_q    <= '0;
      end else begin
         state_q   <= state_d;
         balance_q <= balance_d;
         wait_q    <= wait_d;
         item_q    <= item_d;
         coin_q    <= coin_d;
      end
   end

   always_comb begin
      o_available_item = '0;
      for (int k = 0; k < kNumItems; k++) begin
         o_available_item[k] = (balance_q >= item_price(k));
      end
   end

   assign o_output_item   = item_q;
   assign o_return_coin   = coin_q;
   assign o_current_total = balance_q;
   assign o_state         = state_q;
   assign o_busy          = (state_q == S_RETURN);

endmodule

// File: tb/tb_vending_machine_controller.sv
// Self-checking bench for vending_machine_controller: directed vector table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_vending_machine_controller;
   localparam int kNumCoins  = 3;
   localparam int kNumItems  = 4;
   localparam int kTotalBits = 31;
   localparam int kWaitTime  = 100;
   localparam longint kMaxBal = (longint'(1) << kTotalBits) - 1;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [kNumCoins-1:0]  i_input_coin;
   logic [kNumItems-1:0]  i_select_item;
   logic                  i_trigger_return;
   logic [kNumItems-1:0]  o_available_item;
   logic [kNumItems-1:0]  o_output_item;
   logic [kNumCoins-1:0]  o_return_coin;
   logic [kTotalBits-1:0] o_current_total;
   logic [1:0]            o_state;
   logic                  o_busy;

   int total_cnt = 0;
   int bad_cnt   = 0;

   int coin_vals[3]   = '{100, 500, 1000};
   int item_prices[4] = '{400, 500, 1000, 2000};

   longint     m_bal;
   int         m_mode;
   int         m_since;
   logic [3:0] m_item;
   logic [2:0] m_coin;

   typedef struct {
      logic [2:0] coin;
      logic [3:0] item;
      logic       ret;
      int         total;
      logic [3:0] out_item;
      logic [2:0] ret_coin;
      int         st;
      logic [3:0] avail;
   } vec_t;

   vec_t vecs[17];

   vending_machine_controller dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i_input_coin     (i_input_coin),
      .i_select_item    (i_select_item),
      .i_trigger_return (i_trigger_return),
      .o_available_item (o_available_item),
      .o_output_item    (o_output_item),
      .o_return_coin    (o_return_coin),
      .o_current_total  (o_current_total),
      .o_state          (o_state),
      .o_busy           (o_busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_bal   = 0;
      m_mode  = 0;
      m_since = 0;
      m_item  = '0;
      m_coin  = '0;
   endtask

   // Behavioural rules: mode 0/1/2 = idle/active/return, m_since counts
   // quiet active cycles since the last coin or purchase.
   task automatic model_step(input logic [2:0] coin, input logic [3:0] item, input logic ret);
      int cidx, sidx, pick;
      longint c, p;
      cidx = -1;
      sidx = -1;
      pick = -1;
      for (int i = 0; i < 3; i++) if (coin[i] && cidx < 0) cidx = i;
      for (int i = 0; i < 4; i++) if (item[i] && sidx < 0) sidx = i;
      m_item = '0;
      m_coin = '0;
      case (m_mode)
         0: begin
            if (cidx >= 0) begin
               m_bal   += coin_vals[cidx];
               m_mode  = 1;
               m_since = 0;
            end
         end
         1: begin
            c = 0;
            if (cidx >= 0 && m_bal + coin_vals[cidx] <= kMaxBal) c = coin_vals[cidx];
            p = (sidx >= 0) ? item_prices[sidx] : 0;
            if (ret) begin
               m_bal  += c;
               m_mode = 2;
            end else if (sidx >= 0 && m_bal + c >= p) begin
               m_bal        = m_bal + c - p;
               m_item[sidx] = 1'b1;
               m_since      = 0;
            end else begin
               m_bal += c;
               if (c != 0) begin
                  m_since = 0;
               end else begin
                  m_since++;
                  if (m_since >= kWaitTime) m_mode = 2;
               end
            end
         end
         default: begin
            for (int i = 0; i < 3; i++) if (coin_vals[i] <= m_bal) pick = i;
            if (pick >= 0) begin
               m_bal        -= coin_vals[pick];
               m_coin[pick] = 1'b1;
               if (m_bal == 0) m_mode = 0;
            end else begin
               m_bal  = 0;
               m_mode = 0;
            end
         end
      endcase
   endtask

   function automatic logic [3:0] model_avail();
      logic [3:0] a;
      a = '0;
      for (int k = 0; k < 4; k++) a[k] = (m_bal >= item_prices[k]);
      return a;
   endfunction

   task automatic check_output(input string tag);
      check_val({tag, ".total"}, 32'(o_current_total), 32'(m_bal));
      check_val({tag, ".item"},  32'(o_output_item),   32'(m_item));
      check_val({tag, ".coin"},  32'(o_return_coin),   32'(m_coin));
      check_val({tag, ".state"}, 32'(o_state),         32'(m_mode));
      check_val({tag, ".busy"},  32'(o_busy),          32'(m_mode == 2));
      check_val({tag, ".avail"}, 32'(o_available_item), 32'(model_avail()));
   endtask

   task automatic apply_stimulus(input logic [2:0] coin, input logic [3:0] item, input logic ret);
      i_input_coin     = coin;
      i_select_item    = item;
      i_trigger_return = ret;
      @(posedge clk);
      model_step(coin, item, ret);
      #1;
      i_input_coin     = '0;
      i_select_item    = '0;
      i_trigger_return = 1'b0;
   endtask

   task automatic do_reset();
      reset_n          = 1'b0;
      i_input_coin     = '0;
      i_select_item    = '0;
      i_trigger_return = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      check_output("reset");
   endtask

   task automatic check_brief(input string tag, input int total, input logic [2:0] coin, input int st);
      check_val({tag, ".total"}, 32'(o_current_total), 32'(total));
      check_val({tag, ".coin"},  32'(o_return_coin),   32'(coin));
      check_val({tag, ".state"}, 32'(o_state),         32'(st));
   endtask

   initial begin
      vecs[0]  = '{3'b100, 4'b0000, 1'b0, 1000, 4'b0000, 3'b000, 1, 4'b0111};
      vecs[1]  = '{3'b000, 4'b0000, 1'b0, 1000, 4'b0000, 3'b000, 1, 4'b0111};
      vecs[2]  = '{3'b000, 4'b0010, 1'b0,  500, 4'b0010, 3'b000, 1, 4'b0011};
      vecs[3]  = '{3'b000, 4'b1000, 1'b0,  500, 4'b0000, 3'b000, 1, 4'b0011};
      vecs[4]  = '{3'b011, 4'b0000, 1'b0,  600, 4'b0000, 3'b000, 1, 4'b0011};
      vecs[5]  = '{3'b010, 4'b0001, 1'b0,  700, 4'b0001, 3'b000, 1, 4'b0011};
      vecs[6]  = '{3'b001, 4'b0001, 1'b1,  800, 4'b0000, 3'b000, 2, 4'b0011};
      vecs[7]  = '{3'b000, 4'b0000, 1'b0,  300, 4'b0000, 3'b010, 2, 4'b0000};
      vecs[8]  = '{3'b000, 4'b0000, 1'b0,  200, 4'b0000, 3'b001, 2, 4'b0000};
      vecs[9]  = '{3'b100, 4'b0001, 1'b1,  100, 4'b0000, 3'b001, 2, 4'b0000};
      vecs[10] = '{3'b000, 4'b0000, 1'b0,    0, 4'b0000, 3'b001, 0, 4'b0000};
      vecs[11] = '{3'b000, 4'b0001, 1'b1,    0, 4'b0000, 3'b000, 0, 4'b0000};
      vecs[12] = '{3'b010, 4'b0010, 1'b0,  500, 4'b0000, 3'b000, 1, 4'b0011};
      vecs[13] = '{3'b000, 4'b0010, 1'b0,    0, 4'b0010, 3'b000, 1, 4'b0000};
      vecs[14] = '{3'b010, 4'b0001, 1'b0,  100, 4'b0001, 3'b000, 1, 4'b0000};
      vecs[15] = '{3'b000, 4'b0000, 1'b1,  100, 4'b0000, 3'b000, 2, 4'b0000};
      vecs[16] = '{3'b000, 4'b0000, 1'b0,    0, 4'b0000, 3'b001, 0, 4'b0000};

      do_reset();
      for (int i = 0; i < 17; i++) begin
         apply_stimulus(vecs[i].coin, vecs[i].item, vecs[i].ret);
         check_val($sformatf("vec%0d.total", i), 32'(o_current_total), 32'(vecs[i].total));
         check_val($sformatf("vec%0d.item", i),  32'(o_output_item),   32'(vecs[i].out_item));
         check_val($sformatf("vec%0d.coin", i),  32'(o_return_coin),   32'(vecs[i].ret_coin));
         check_val($sformatf("vec%0d.state", i), 32'(o_state),         32'(vecs[i].st));
         check_val($sformatf("vec%0d.busy", i),  32'(o_busy),          32'(vecs[i].st == 2));
         check_val($sformatf("vec%0d.avail", i), 32'(o_available_item), 32'(vecs[i].avail));
      end

      $display("[TB] change return of 1600");
      do_reset();
      apply_stimulus(3'b100, 4'b0000, 1'b0);
      apply_stimulus(3'b010, 4'b0000, 1'b0);
      apply_stimulus(3'b001, 4'b0000, 1'b0);
      check_brief("chg.loaded", 1600, 3'b000, 1);
      apply_stimulus(3'b000, 4'b0000, 1'b1);
      check_brief("chg.enter", 1600, 3'b000, 2);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("chg.c1", 600, 3'b100, 2);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("chg.c2", 100, 3'b010, 2);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("chg.c3", 0, 3'b001, 0);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("chg.after", 0, 3'b000, 0);

      $display("[TB] inactivity timeout");
      do_reset();
      apply_stimulus(3'b010, 4'b0000, 1'b0);
      apply_stimulus(3'b001, 4'b0000, 1'b0);
      for (int i = 1; i <= kWaitTime - 1; i++) apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("tmo.e99", 600, 3'b000, 1);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("tmo.e100", 600, 3'b000, 2);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("tmo.e101", 100, 3'b010, 2);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("tmo.e102", 0, 3'b001, 0);

      $display("[TB] failed purchase leaves timer running");
      do_reset();
      repeat (4) apply_stimulus(3'b001, 4'b0000, 1'b0);
      for (int i = 1; i <= 10; i++) apply_stimulus(3'b000, 4'b0000, 1'b0);
      apply_stimulus(3'b000, 4'b1000, 1'b0);
      check_val("poor.item", 32'(o_output_item), 32'd0);
      check_val("poor.total", 32'(o_current_total), 32'd400);
      for (int i = 12; i <= kWaitTime - 1; i++) apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("poor.e99", 400, 3'b000, 1);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("poor.e100", 400, 3'b000, 2);

      $display("[TB] asynchronous reset");
      do_reset();
      apply_stimulus(3'b100, 4'b0000, 1'b0);
      apply_stimulus(3'b010, 4'b0000, 1'b0);
      check_brief("arst.pre", 1500, 3'b000, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_brief("arst.now", 0, 3'b000, 0);
      check_val("arst.busy", 32'(o_busy), 32'd0);
      check_val("arst.avail", 32'(o_available_item), 32'd0);
      i_input_coin = 3'b100;
      @(posedge clk);
      #1;
      check_brief("arst.held", 0, 3'b000, 0);
      i_input_coin = '0;
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      apply_stimulus(3'b100, 4'b0000, 1'b0);
      apply_stimulus(3'b100, 4'b0000, 1'b0);
      apply_stimulus(3'b000, 4'b0000, 1'b1);
      apply_stimulus(3'b000, 4'b0000, 1'b0);
      check_brief("arst.midret", 1000, 3'b100, 2);
      #2;
      reset_n = 1'b0;
      #1;
      check_brief("arst.ret", 0, 3'b000, 0);
      check_val("arst.retbusy", 32'(o_busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();

      $display("[TB] randomized traffic");
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         int density;
         density = $urandom_range(0, 3);
         for (int cyc = 0; cyc < 200; cyc++) begin
            logic [2:0] c;
            logic [3:0] s;
            logic       r;
            c = '0;
            s = '0;
            r = 1'b0;
            if (density != 0) begin
               if ($urandom_range(0, 3) < density) c = 3'($urandom_range(1, 7));
               if ($urandom_range(0, 4) < density) s = 4'($urandom_range(1, 15));
               r = ($urandom_range(0, 60) == 0);
            end
            apply_stimulus(c, s, r);
            check_output($sformatf("rnd%0d.%0d", blk, cyc));
         end
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/vending_machine_controller.md
# vending_machine_controller

Sequencing controller for the vending machine. It owns the registered balance, the inactivity timer and the change-return sequencer. It turns one-hot coin, item and return pulses into one-cycle registered dispense and coin-return pulses. It sits between the front-panel inputs and the display/dispense outputs, and performs the next-balance arithmetic itself.

## Interface
- kNumCoins, 3, coin denominations
- kNumItems, 4, items
- kTotalBits, 31, balance width
- kWaitTime, 100, inactivity cycles before auto-return
- COIN_VAL0/1/2, 100/500/1000, coin values (ascending)
- ITEM_PRICE0/1/2/3, 400/500/1000/2000, item prices (ascending)
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_input_coin  in  kNumCoins  coin-insert pulse, one-hot
- i_select_item  in  kNumItems  item-select pulse, one-hot
- i_trigger_return  in  1  return-change request
- o_available_item  out  kNumItems  bit k set when balance >= ITEM_PRICEk (combinational from registered balance)
- o_output_item  out  kNumItems  registered one-cycle dispense pulse
- o_return_coin  out  kNumCoins  registered one-cycle returned-coin pulse, one-hot
- o_current_total  out  kTotalBits  registered balance
- o_state  out  2  0=IDLE, 1=ACTIVE, 2=RETURN
- o_busy  out  1  high in RETURN

## Operation
- Multi-hot input: lowest set index wins; other bits ignored.
- State IDLE, balance 0:
  - A coin adds its value and moves the block to ACTIVE.
  - Select and return requests are ignored.
- State ACTIVE:
  - Let C be the accepted coin value, or 0 if none.
  - Let P be the selected price, or 0 if none.
  - If balance+C >= P and a select is present: balance <= balance+C-P, and o_output_item pulses the selected bit.
  - Otherwise: balance <= balance+C, and a select is dropped with no pulse.
  - A coin or a successful dispense reloads wait_cnt to kWaitTime; any other cycle decrements it.
  - wait_cnt going 1->0 moves the block to RETURN.
  - i_trigger_return moves the block to RETURN at the next edge.
  - A same-cycle coin is still added; a same-cycle select is ignored.
  - If the balance becomes 0 and there is no trigger, the block stays in ACTIVE until timeout.
- State RETURN:
  - At each edge with balance T > 0: o_return_coin <= the largest coin with value <= T, and balance <= T minus that value.
  - When the new balance is 0, state <= IDLE at the same edge.
  - If T is less than COIN_VAL0, the balance is cleared and the block returns to IDLE with no pulse.
  - All inputs are ignored in RETURN.
- Overflow: a coin that would make the balance exceed 2^kTotalBits-1 is ignored. It causes no balance change and no timer reload.

## Timing
- Reset (asynchronous, any state, including mid-RETURN):
  - state=IDLE, balance=0, wait_cnt=0.
  - o_output_item=0, o_return_coin=0, o_current_total=0, o_busy=0.
  - Pending change is discarded.
- An input sampled at edge N is reflected in o_current_total and o_output_item during cycle N+1.
- o_output_item and o_return_coin are high for exactly one cycle per event; they are 0 otherwise.
- Timeout: with the last coin or dispense at edge E, RETURN is entered at edge E+kWaitTime. The first return coin appears at edge E+kWaitTime+1.
- Return of balance T takes one cycle per greedy coin. IDLE is reached at the edge that emits the last coin.
- o_available_item follows o_current_total combinationally with no extra latency.

## Test plan
- Reset:
  - Stimulus: assert reset_n=0 mid-ACTIVE with balance 1500.
  - Response: all outputs 0 and state IDLE immediately, without waiting for a clock edge; inputs are ignored until release.
- Purchase:
  - Stimulus: coin 1000, then select item1 two cycles later.
  - Response: o_output_item=0010 for one cycle, balance 500, o_available_item=0011.
- Change return:
  - Stimulus: insert 1000, 500, 100 (balance 1600), then i_trigger_return.
  - Response: o_return_coin=100, 010, 001 on three consecutive cycles, then IDLE, balance 0.
- Simultaneous coin and select:
  - Stimulus: balance 0 in ACTIVE; same cycle: coin 500 and select item0 (400).
  - Response: dispense 0001, balance 100.
- Insufficient funds:
  - Stimulus: balance 400; select item3.
  - Response: no o_output_item pulse, balance unchanged, timer not reloaded.
- Timeout with kWaitTime=100:
  - Stimulus: last coin at edge E (balance 600); no further inputs.
  - Response: RETURN at E+100; coins 010 then 001; IDLE at E+102.
